// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
// Round-robin arbiter that shares one single-port sprite ROM among N asteroid
// slots. It can issue one read per cycle, and each read is issued
// combinationally in the cycle it is granted. A LAT-deep tag pipeline tracks
// which slot owns each returning palette index. rom_data is captured on the
// edge that ends cycle grant+LAT-1, so rd_valid and rd_data appear together
// LAT cycles after the grant. While vs is low (blanking) the FSM sits in
// FLUSH: it issues no new reads, lets in-flight reads drain, and parks the
// round-robin pointer at slot 0.
module sprite_rom_arbiter #(
  parameter int N      = 4,
  parameter int ADDR_W = 19,
  parameter int LAT    = 1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     vs,
  input  logic [N-1:0]             req,
  input  logic [N-1:0][ADDR_W-1:0] req_addr,
  output logic [N-1:0]             grant,
  output logic [ADDR_W-1:0]        rom_addr,
  output logic                     rom_rd,
  input  logic [3:0]               rom_data,
  output logic [N-1:0]             rd_valid,
  output logic [3:0]               rd_data,
  output logic                     busy
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  ptr, ptr_nxt;
  logic              issue_ok;
  logic              gnt_any;
  logic [IDX_W-1:0]  gnt_idx;
  logic [IDX_W-1:0]  cand;
  logic [ADDR_W-1:0] addr_q;
  tag_t [LAT-1:0]    tag_q;
  logic              in_flight;
  logic              cap_valid;

  // Grants are only issued in RUN with vs high; Reset also suppresses them.
  // Gating on vs means a low vs stops new reads in the cycle it appears.
  assign issue_ok = (state == RUN) && vs && !Reset;

  // Round-robin search: start at ptr and take the first active requester.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (issue_ok) begin
      for (int i = 0; i < N; i++) begin
        cand = IDX_W'((int'(ptr) + i) % N);
        if (!gnt_any && req[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  // Next state and next pointer. FLUSH parks ptr at 0 until blanking ends.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    unique case (state)
      RUN: begin
        if (!vs) state_nxt = FLUSH;
        if (gnt_any) ptr_nxt = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + IDX_W'(1);
      end
      FLUSH: begin
        ptr_nxt = '0;
        if (vs && !in_flight) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // State register and round-robin pointer; Reset has priority over vs/req.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the values from before the edge regardless of statement order.
    if (Reset) begin
      state <= RUN;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Any stage holding a valid tag means a read is still in flight.
  always_comb begin
    in_flight = 1'b0;
    for (int i = 0; i < LAT; i++) in_flight = in_flight | tag_q[i].valid;
  end

  // rom_data is captured one stage before the tag reaches the output.
  if (LAT == 1) begin : g_cap_direct
    assign cap_valid = gnt_any;
  end else begin : g_cap_tag
    assign cap_valid = tag_q[LAT-2].valid;
  end

  // Address hold register, tag pipeline and returned-data register. On
  // Reset every tag is cleared, so reads still in flight never report back.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      addr_q  <= '0;
      tag_q   <= '0;
      rd_data <= '0;
    end else begin
      if (gnt_any) addr_q <= req_addr[gnt_idx];
      tag_q[0] <= tag_t'{valid: gnt_any, idx: gnt_idx};
      for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
      if (cap_valid) rd_data <= rom_data;
    end
  end

  // Decode the grant and the last tag stage into one-hot strobes.
  always_comb begin
    grant    = '0;
    rd_valid = '0;
    for (int k = 0; k < N; k++) begin
      grant[k]    = gnt_any && (gnt_idx == IDX_W'(k));
      rd_valid[k] = tag_q[LAT-1].valid && (tag_q[LAT-1].idx == IDX_W'(k));
    end
  end

  assign rom_rd   = gnt_any;
  assign rom_addr = gnt_any ? req_addr[gnt_idx] : addr_q;
  assign busy     = (state == FLUSH) || in_flight;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter
// Directed bench that drives two instances in lockstep, one with LAT=1 and one
// with LAT=2. Each cycle it applies a vector and checks that cycle's grant,
// ROM-side outputs, returned data and (optionally) busy against hand-written
// expectations. Each ROM model returns (7*addr + 3) mod 16, so address 11
// maps to palette index 0 (transparent).
module tb_sprite_rom_arbiter;

  localparam int N      = 4;
  localparam int ADDR_W = 19;

  logic                     Clk = 1'b0;
  logic                     Reset;
  logic                     vs;
  logic [N-1:0]             req;
  logic [N-1:0][ADDR_W-1:0] req_addr;

  logic [N-1:0]      grant1, grant2, rd_valid1, rd_valid2;
  logic [ADDR_W-1:0] rom_addr1, rom_addr2, addr2_q;
  logic              rom_rd1, rom_rd2, busy1, busy2;
  logic [3:0]        rom_data1, rom_data2, rd_data1, rd_data2;

  int total = 0;
  int bad   = 0;

  // Expected-return delay lines (grant vector and data) for each latency.
  logic [3:0]        p1_g = '0;
  logic [3:0]        rdd1 = '0;
  logic [3:0]        p2_g [2] = '{4'b0, 4'b0};
  logic [3:0]        p2_d [2] = '{4'b0, 4'b0};
  logic [3:0]        rdd2 = '0;
  logic [ADDR_W-1:0] last_addr = '0;

  always #5 Clk = ~Clk;

  function automatic logic [3:0] rom_f(input logic [ADDR_W-1:0] a);
    logic [31:0] t;
    t = {13'b0, a} * 32'd7 + 32'd3;
    return t[3:0];
  endfunction

  // ROM with LAT=1: data is combinational from the address.
  assign rom_data1 = rom_f(rom_addr1);

  // ROM with LAT=2: one address register ahead of the lookup.
  always_ff @(posedge Clk) addr2_q <= rom_addr2;
  assign rom_data2 = rom_f(addr2_q);

  sprite_rom_arbiter #(.N(N), .ADDR_W(ADDR_W), .LAT(1)) u_dut1 (
    .Clk(Clk), .Reset(Reset), .vs(vs), .req(req), .req_addr(req_addr),
    .grant(grant1), .rom_addr(rom_addr1), .rom_rd(rom_rd1), .rom_data(rom_data1),
    .rd_valid(rd_valid1), .rd_data(rd_data1), .busy(busy1)
  );

  sprite_rom_arbiter #(.N(N), .ADDR_W(ADDR_W), .LAT(2)) u_dut2 (
    .Clk(Clk), .Reset(Reset), .vs(vs), .req(req), .req_addr(req_addr),
    .grant(grant2), .rom_addr(rom_addr2), .rom_rd(rom_rd2), .rom_data(rom_data2),
    .rd_valid(rd_valid2), .rd_data(rd_data2), .busy(busy2)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check at the falling edge, advance the
  // expectation model at the rising edge. eb1/eb2 = -1 skips the busy check.
  task automatic cyc(input logic rst, input logic v, input logic [3:0] r,
                     input logic [3:0] eg, input int eb1, input int eb2,
                     input string tag);
    logic [ADDR_W-1:0] ea;
    logic [3:0]        ed;
    Reset = rst;
    vs    = v;
    req   = r;
    ea    = last_addr;
    for (int i = 0; i < N; i++) if (eg[i]) ea = req_addr[i];
    ed = rom_f(ea);
    @(negedge Clk);
    check({tag, " grant1"},    32'(grant1),    32'(eg));
    check({tag, " grant2"},    32'(grant2),    32'(eg));
    check({tag, " rom_rd1"},   32'(rom_rd1),   32'(|eg));
    check({tag, " rom_rd2"},   32'(rom_rd2),   32'(|eg));
    check({tag, " rom_addr1"}, 32'(rom_addr1), 32'(ea));
    check({tag, " rom_addr2"}, 32'(rom_addr2), 32'(ea));
    check({tag, " rd_valid1"}, 32'(rd_valid1), 32'(p1_g));
    check({tag, " rd_data1"},  32'(rd_data1),  32'(rdd1));
    check({tag, " rd_valid2"}, 32'(rd_valid2), 32'(p2_g[1]));
    check({tag, " rd_data2"},  32'(rd_data2),  32'(rdd2));
    if (eb1 >= 0) check({tag, " busy1"}, 32'(busy1), eb1);
    if (eb2 >= 0) check({tag, " busy2"}, 32'(busy2), eb2);
    @(posedge Clk);
    if (rst) begin
      p1_g      = '0;
      p2_g[0]   = '0;
      p2_g[1]   = '0;
      rdd1      = '0;
      rdd2      = '0;
      last_addr = '0;
    end else begin
      if (eg != 4'b0) begin
        rdd1      = ed;
        last_addr = ea;
      end
      if (p2_g[0] != 4'b0) rdd2 = p2_d[0];
      p1_g    = eg;
      p2_g[1] = p2_g[0];
      p2_d[1] = p2_d[0];
      p2_g[0] = eg;
      p2_d[0] = ed;
    end
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    vs    = 1'b1;
    req   = '0;
    for (int i = 0; i < N; i++) req_addr[i] = ADDR_W'(100 * i);
    repeat (2) @(posedge Clk);
    #1;

    // Reset state: everything idle and zero.
    cyc(0, 1, 4'b0000, 4'b0000, 0, 0, "rst_state");

    // All four requesting: strict rotation 0,1,2,3,0,1,2,3.
    cyc(0, 1, 4'b1111, 4'b0001, 0, 0, "rr0");
    cyc(0, 1, 4'b1111, 4'b0010, 1, 1, "rr1");
    cyc(0, 1, 4'b1111, 4'b0100, 1, 1, "rr2");
    cyc(0, 1, 4'b1111, 4'b1000, 1, 1, "rr3");
    cyc(0, 1, 4'b1111, 4'b0001, 1, 1, "rr4");
    cyc(0, 1, 4'b1111, 4'b0010, 1, 1, "rr5");
    cyc(0, 1, 4'b1111, 4'b0100, 1, 1, "rr6");
    cyc(0, 1, 4'b1111, 4'b1000, 1, 1, "rr7");
    cyc(0, 1, 4'b0000, 4'b0000, 1, 1, "rr_drain0");
    cyc(0, 1, 4'b0000, 4'b0000, 0, 1, "rr_drain1");

    // Single requester at address 55 is granted every cycle.
    req_addr[2] = ADDR_W'(55);
    for (int i = 0; i < 5; i++) cyc(0, 1, 4'b0100, 4'b0100, -1, -1, $sformatf("solo%0d", i));
    cyc(0, 1, 4'b0000, 4'b0000, 1, 1, "solo_drain0");
    cyc(0, 1, 4'b0000, 4'b0000, 0, 1, "solo_drain1");

    // ptr is 3: search wraps to 0 first, then 1. Slot 0 reads transparent 0.
    req_addr[0] = ADDR_W'(11);
    cyc(0, 1, 4'b0011, 4'b0001, 0, 0, "wrap0");
    cyc(0, 1, 4'b0011, 4'b0010, 1, 1, "wrap1");
    cyc(0, 1, 4'b0000, 4'b0000, 1, 1, "wrap_drain0");
    cyc(0, 1, 4'b0000, 4'b0000, 0, 1, "wrap_drain1");

    // ptr is 2: grant slot 1, then blanking. No grants, in-flight read
    // still returns, busy until drained, first grant afterwards to slot 0.
    cyc(0, 1, 4'b0010, 4'b0010, 0, 0, "fl_grant");
    cyc(0, 0, 4'b1111, 4'b0000, 1, 1, "fl_vs_low");
    cyc(0, 0, 4'b1111, 4'b0000, 1, 1, "fl_hold0");
    cyc(0, 0, 4'b1111, 4'b0000, 1, 1, "fl_hold1");
    cyc(0, 1, 4'b1111, 4'b0000, 1, 1, "fl_exit");
    cyc(0, 1, 4'b1111, 4'b0001, 0, 0, "fl_first");
    cyc(0, 1, 4'b0000, 4'b0000, 1, 1, "fl_drain0");
    cyc(0, 1, 4'b0000, 4'b0000, 0, 1, "fl_drain1");

    // ptr is 1: grant slot 1, then Reset. The LAT=2 read is discarded, all
    // outputs are zero afterwards, and ptr is back at 0.
    cyc(0, 1, 4'b0010, 4'b0010, -1, -1, "rst_grant");
    cyc(1, 1, 4'b0000, 4'b0000, -1, -1, "rst_pulse");
    cyc(0, 1, 4'b0000, 4'b0000, 0, 0, "rst_after");
    cyc(0, 1, 4'b1111, 4'b0001, 0, 0, "rst_ptr0");
    cyc(0, 1, 4'b0000, 4'b0000, 1, 1, "rst_drain0");
    cyc(0, 1, 4'b0000, 4'b0000, 0, 1, "rst_drain1");

    // Reset together with vs low: RUN with ptr 0, then FLUSH while vs low.
    cyc(0, 1, 4'b0001, 4'b0001, 0, 0, "rv_grant");
    cyc(1, 0, 4'b0000, 4'b0000, -1, -1, "rv_reset");
    cyc(0, 0, 4'b1111, 4'b0000, 0, 0, "rv_run");
    cyc(0, 0, 4'b1111, 4'b0000, 1, 1, "rv_flush");
    cyc(0, 1, 4'b1111, 4'b0000, 1, 1, "rv_exit");
    cyc(0, 1, 4'b1111, 4'b0001, 0, 0, "rv_first");
    cyc(0, 1, 4'b0000, 4'b0000, 1, 1, "rv_drain0");
    cyc(0, 1, 4'b0000, 4'b0000, 0, 1, "rv_drain1");
    cyc(0, 1, 4'b0000, 4'b0000, 0, 0, "rv_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
